inst_fetch_bridge: RTL and testbench
====================================

# inst_fetch_bridge

Instruction-side responder for the PC stage: takes the fetch address and chip enable from the program-counter register, issues it as a request on an SRAM-like instruction bus, and returns the fetched instruction to the decode stage. It drives `inst_stall` (bit 0 of the pipeline stall vector) so the PC holds until an instruction is delivered. It also holds the delivered word while later stages are stalled. It sits between the PC register and the instruction memory / AXI-bridge port.

## Interface
- `RESET_PC`, default 32'hbfc0_0000: reset fetch address. Used only by the bench for checking; the bridge itself does not store it.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous reset, active-low.
- `pc_i` in 32: fetch address from the PC register.
- `ce_i` in 1: fetch enable from the PC register.
- `pipe_stall_i` in 1: OR of id/exe/data stalls (stall[3:1]). When 1, the held instruction is not consumed.
- `inst_stall_o` out 1: bit 0 of the pipeline stall vector.
- `inst_o` out 32: instruction to decode.
- `adel_o` out 1: instruction address error (see Configuration).
- `inst_req` out 1: bus request.
- `inst_wr` out 1: constant 0.
- `inst_size` out 2: constant 2'b10 (word).
- `inst_addr` out 32: bus address.
- `inst_addr_ok` in 1: request accepted.
- `inst_data_ok` in 1: read data valid.
- `inst_rdata` in 32: read data.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Encoded in a 2-bit state register.
- **IDLE**
  - `ce_i`=1 → REQ.
  - Otherwise stay in IDLE.
- **REQ**
  - `inst_req`=1 and `inst_addr`={`pc_i`[31:2],2'b00}.
  - `pc_i` is stable in this state because `inst_stall_o`=1.
  - `inst_addr_ok`=1 and `inst_data_ok`=1 in the same cycle → capture `inst_rdata`, go to DONE.
  - `inst_addr_ok` only → WAIT.
  - `inst_data_ok` without `inst_addr_ok` is stale; ignore it.
- **WAIT**
  - `inst_req`=0.
  - `inst_data_ok`=1 → capture `inst_rdata` into the instruction buffer, go to DONE.
- **DONE**
  - Buffer is valid.
  - `pipe_stall_i`=0: the instruction is consumed at this edge. The PC advances at the same edge. Next state is REQ if `ce_i`=1, else IDLE.
  - `pipe_stall_i`=1: stay in DONE and hold the buffer.
- `inst_stall_o` = (state != DONE), decoded from registered state.
  - It is 1 in IDLE even with `ce_i`=0. This prevents the PC from incrementing past the reset vector before `ce_i` rises.
- `inst_o` = buffer in DONE, 32'h0 (nop) in every other state.
- `inst_data_ok` arriving in IDLE or DONE is ignored.
- At most one outstanding request at any time.

## Timing
- Reset (`rst`=0 at a rising edge):
  - state=IDLE, buffer=0, `adel_o`=0.
  - Outputs: `inst_req`=0, `inst_o`=0, `inst_stall_o`=1.
- Reset mid-transaction (REQ/WAIT) abandons the request. The memory side shares the reset.
- Best case (addr_ok and data_ok in the same cycle):
  - REQ in cycle n, DONE in cycle n+1.
  - 2 cycles per instruction with no pipeline stall.
- With data_ok k cycles after addr_ok: DONE is reached k+1 cycles after addr_ok.
- `inst_addr` is valid only while `inst_req`=1. It must not change while `inst_req`=1 and `inst_addr_ok`=0.
- Buffer capture is a registered write at the edge where data_ok is sampled. `inst_o` is valid the following cycle.

## Configuration
- Macro: `IF_ADDR_ALIGN_CHECK_EN`.
- Defined:
  - In IDLE or DONE→next transition, if `pc_i`[1:0]!=0 → go directly to DONE with buffer=0 and `adel_o`=1. No bus request is issued.
  - `adel_o` clears when DONE is exited.
- Undefined:
  - `adel_o` tied 0.
  - Low address bits are forced to 00 on `inst_addr`; no check is made.

## Test plan
- **Reset hold:** `rst`=0 for 3 cycles, then release with `ce_i`=0 for one cycle.
  - `inst_stall_o`=1 throughout.
  - First `inst_req` carries `inst_addr`=32'hbfc0_0000.
- **Zero-wait fetch:** memory returns addr_ok+data_ok in the same cycle, rdata=32'h2408_0001, `pipe_stall_i`=0.
  - `inst_o`=32'h2408_0001 one cycle later.
  - Next request at 32'hbfc0_0004, two cycles after the first.
- **Slow memory:** addr_ok after 2 cycles, data_ok 3 cycles later.
  - `inst_req` drops after addr_ok.
  - `inst_stall_o`=1 for 6 cycles, then `inst_o` is valid.
- **Downstream stall:** `pipe_stall_i`=1 for 4 cycles while in DONE.
  - `inst_o` is held constant.
  - `inst_req`=0 and no new request is issued.
  - Spurious `inst_data_ok` pulses with rdata=32'hdead_beef do not alter `inst_o`.
- **Reset mid-transaction:** assert `rst` in WAIT, then deliver data_ok after release.
  - The stale data_ok is ignored and `inst_o` stays 0.
  - The first new request goes to the reset vector.
- **Misaligned PC with `IF_ADDR_ALIGN_CHECK_EN`:** `pc_i`=32'hbfc0_0002.
  - No `inst_req`.
  - `adel_o`=1 and `inst_o`=0 in DONE.

Source files
------------

// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: turns the PC stage's fetch address into a single-outstanding
// SRAM-like bus read and holds the returned word for decode. Optional macro: IF_ADDR_ALIGN_CHECK_EN.
module inst_fetch_bridge #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        ce_i,
    input  logic        pipe_stall_i,
    output logic        inst_stall_o,
    output logic [31:0] inst_o,
    output logic        adel_o,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] buf_q, buf_d;
    logic        adel_q, adel_d;
    logic        misalign;

    // RESET_PC belongs to the surrounding PC register; kept only so both sides share one value.
    logic unused_cfg;
    assign unused_cfg = ^{RESET_PC, pc_i[1:0]};

`ifdef IF_ADDR_ALIGN_CHECK_EN
    assign misalign = (pc_i[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            buf_q   <= 32'h0;
            adel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            adel_q  <= adel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        adel_d  = adel_q;
        case (state_q)
            IDLE: begin
                if (ce_i && misalign) begin
                    state_d = DONE;
                    buf_d   = 32'h0;
                    adel_d  = 1'b1;
                end else if (ce_i) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // data_ok without addr_ok belongs to an abandoned request and is dropped.
                if (inst_addr_ok && inst_data_ok) begin
                    state_d = DONE;
                    buf_d   = inst_rdata;
                end else if (inst_addr_ok) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (inst_data_ok) begin
                    state_d = DONE;
                    buf_d   = inst_rdata;
                end
            end
            DONE: begin
                if (!pipe_stall_i) begin
                    adel_d = 1'b0;
                    if (ce_i && misalign) begin
                        state_d = DONE;
                        buf_d   = 32'h0;
                        adel_d  = 1'b1;
                    end else if (ce_i) begin
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inst_req     = (state_q == REQ);
        inst_addr    = {pc_i[31:2], 2'b00};
        inst_stall_o = (state_q != DONE);
        inst_o       = (state_q == DONE) ? buf_q : 32'h0;
    end

    assign inst_wr   = 1'b0;
    assign inst_size = 2'b10;
    assign adel_o    = adel_q;

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed bench for inst_fetch_bridge with a simple PC register model on the stall vector.
module tb_inst_fetch_bridge;
    localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_i;
    logic        pipe_stall_i;
    logic        inst_stall_o;
    logic [31:0] inst_o;
    logic        adel_o;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic [31:0] pc_q;
    logic        ovr;
    logic [31:0] ovr_pc;
    int          n_chk  = 0;
    int          n_pass = 0;
    int          stall_cnt;

    always #5 clk = ~clk;

    inst_fetch_bridge #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .ce_i         (ce_i),
        .pipe_stall_i (pipe_stall_i),
        .inst_stall_o (inst_stall_o),
        .inst_o       (inst_o),
        .adel_o       (adel_o),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata)
    );

    // PC register: holds on any stall bit, restarts at the reset vector.
    always @(posedge clk) begin
        if (!rst) pc_q <= RESET_PC;
        else if (!inst_stall_o && !pipe_stall_i) pc_q <= pc_q + 32'd4;
    end
    assign pc_i = ovr ? ovr_pc : pc_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b0; ce_i = 1'b0; pipe_stall_i = 1'b0; ovr = 1'b0; ovr_pc = 32'h0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;

        // reset hold
        repeat (3) begin
            @(negedge clk);
            chk("rst_stall", {31'h0, inst_stall_o}, 32'd1);
            chk("rst_req",   {31'h0, inst_req}, 32'd0);
            chk("rst_inst",  inst_o, 32'h0);
            chk("rst_adel",  {31'h0, adel_o}, 32'd0);
        end
        chk("const_wr",   {31'h0, inst_wr}, 32'd0);
        chk("const_size", {30'h0, inst_size}, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_stall", {31'h0, inst_stall_o}, 32'd1);
        chk("idle_req",   {31'h0, inst_req}, 32'd0);
        ce_i = 1'b1;
        @(negedge clk);
        chk("req0",  {31'h0, inst_req}, 32'd1);
        chk("addr0", inst_addr, 32'hbfc0_0000);

        // zero-wait fetch
        inst_addr_ok = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'h2408_0001;
        @(negedge clk);
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
        chk("zw_inst",  inst_o, 32'h2408_0001);
        chk("zw_stall", {31'h0, inst_stall_o}, 32'd0);
        chk("zw_req",   {31'h0, inst_req}, 32'd0);
        @(negedge clk);
        chk("req1",  {31'h0, inst_req}, 32'd1);
        chk("addr1", inst_addr, 32'hbfc0_0004);

        // slow memory: addr_ok on 3rd REQ cycle, data_ok 3 cycles after
        stall_cnt = 0;
        inst_rdata = 32'h8c09_0010;
        for (int c = 0; c < 6; c++) begin
            if (inst_stall_o) stall_cnt++;
            if (c <= 2) begin
                chk("slow_req",  {31'h0, inst_req}, 32'd1);
                chk("slow_addr", inst_addr, 32'hbfc0_0004);
            end else begin
                chk("slow_reqdrop", {31'h0, inst_req}, 32'd0);
            end
            inst_addr_ok = (c == 2);
            inst_data_ok = (c == 5);
            @(negedge clk);
        end
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
        chk("slow_stallcnt", stall_cnt, 32'd6);
        chk("slow_stall", {31'h0, inst_stall_o}, 32'd0);
        chk("slow_inst",  inst_o, 32'h8c09_0010);

        // downstream stall with spurious data_ok
        pipe_stall_i = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'hdead_beef;
        repeat (4) begin
            @(negedge clk);
            chk("hold_inst",  inst_o, 32'h8c09_0010);
            chk("hold_req",   {31'h0, inst_req}, 32'd0);
            chk("hold_stall", {31'h0, inst_stall_o}, 32'd0);
            inst_data_ok = ~inst_data_ok;
        end
        pipe_stall_i = 1'b0; inst_data_ok = 1'b0;
        @(negedge clk);
        chk("req2",  {31'h0, inst_req}, 32'd1);
        chk("addr2", inst_addr, 32'hbfc0_0008);

        // reset while in WAIT, stale data_ok afterwards
        inst_addr_ok = 1'b1;
        @(negedge clk);
        inst_addr_ok = 1'b0;
        chk("wait_req",   {31'h0, inst_req}, 32'd0);
        chk("wait_stall", {31'h0, inst_stall_o}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_inst", inst_o, 32'h0);
        rst = 1'b1; ce_i = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hdead_beef;
        @(negedge clk);
        chk("stale_inst",  inst_o, 32'h0);
        chk("stale_stall", {31'h0, inst_stall_o}, 32'd1);
        inst_data_ok = 1'b0; ce_i = 1'b1;
        @(negedge clk);
        chk("req3",  {31'h0, inst_req}, 32'd1);
        chk("addr3", inst_addr, RESET_PC);
        inst_addr_ok = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'h3c1d_0001;
        @(negedge clk);
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
        chk("mrst_fetch", inst_o, 32'h3c1d_0001);

        // misaligned PC
        ce_i = 1'b0;
        @(negedge clk);
        chk("mis_idle", {31'h0, inst_stall_o}, 32'd1);
        ovr = 1'b1; ovr_pc = 32'hbfc0_0002; ce_i = 1'b1;
`ifdef IF_ADDR_ALIGN_CHECK_EN
        @(negedge clk);
        chk("mis_req",   {31'h0, inst_req}, 32'd0);
        chk("mis_adel",  {31'h0, adel_o}, 32'd1);
        chk("mis_inst",  inst_o, 32'h0);
        chk("mis_stall", {31'h0, inst_stall_o}, 32'd0);
        ce_i = 1'b0;
        @(negedge clk);
        chk("mis_adelclr", {31'h0, adel_o}, 32'd0);
        chk("mis_exit",    {31'h0, inst_stall_o}, 32'd1);
`else
        @(negedge clk);
        chk("mis_req",  {31'h0, inst_req}, 32'd1);
        chk("mis_addr", inst_addr, 32'hbfc0_0000);
        chk("mis_adel", {31'h0, adel_o}, 32'd0);
        inst_addr_ok = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'h0000_0001;
        @(negedge clk);
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
        chk("mis_inst", inst_o, 32'h0000_0001);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
